reqack_arb: RTL
===============

// Module: reqack_arb
//
// PURPOSE
// Round-robin arbiter sharing one single-cycle-start/done resource among N
// toggle-handshake requesters (req flips to request, ack flips to complete).
// Each req is synchronised into clk, turned into a pending flag, arbitrated,
// and the winner is sequenced through start/done before its ack is flipped.
// Sits between cross-domain requesters and a shared engine (DMA, flash, CSR bus).
//
// PARAMETERS
// N        4   number of requester channels (2..16)
// SELW     2   width of sel; must equal clog2(N)
//
// PORTS
// clk      in   1     clock
// reset    in   1     synchronous, active-high reset
// req      in   N     per-channel request toggle (async to clk)
// ack      out  N     per-channel ack toggle; request pending while req!=ack
// pending  out  N     registered (synced req != ack) per channel
// grant    out  N     one-hot owner of resource, 0 when idle
// sel      out  SELW  binary index of owner, valid while grant!=0
// start    out  1     one-cycle pulse: resource begins op for sel
// done     in   1     resource completion pulse, sampled only in WAIT
// busy     out  1     state != IDLE
//
// BEHAVIOUR
// - Reset: ack=0, pending=0, grant=0, sel=0, start=0, busy=0, sync flops=0,
//   state=IDLE, round-robin pointer last=N-1 (channel 0 has first priority).
// - Sync: 2-flop synchroniser per req bit; pending <= req_s2 != ack each cycle.
// - FSM states IDLE, START, WAIT, ACK:
//   IDLE : if pending!=0, choose first set bit scanning last+1, last+2, ...
//          modulo N; latch sel/grant; -> START. Else stay.
//   START: start=1 for exactly this cycle; -> WAIT. done here is ignored.
//   WAIT : hold grant/sel; on done=1 flip ack[sel], last<=sel, -> ACK.
//   ACK  : grant=0; one cycle so pending[sel] re-evaluates with new ack;
//          -> IDLE.
// - Latency: req toggle sampled at edge 0 -> pending at edge 2 -> START
//   entered at edge 3 -> start high in cycle after edge 3. done at edge k
//   -> ack flips at edge k; next grant earliest at edge k+2.
// - Wrap-around: pointer scan modulo N; last=N-1 scans from 0.
// - Simultaneous: all-pending served in strict rotation, no channel serviced
//   twice while another is pending. Requester re-toggling in ACK cycle is
//   seen via sync and arbitrated normally.
// - Double toggle of req before ack: indistinguishable from none (protocol
//   violation, no detection). done outside WAIT: ignored, no state change.
// - Reset mid-op (any state): immediate return to reset values, ack forced 0;
//   requesters and resource must be reset together (system requirement).
// - Only one grant bit ever high; grant!=0 exactly in START and WAIT.
//
// TESTING
// 1 Reset then toggle req[2] only -> pending[2] at edge 2, start with sel=2
//   one cycle, done after 5 cycles -> ack[2]=1, grant=0, busy drops 2 cycles on.
// 2 Toggle req[3:0] together -> service order sel=0,1,2,3, each ack flips once,
//   no start pulses in between other than these four.
// 3 last=1 (after serving ch1), pending ch0 and ch3 -> ch3 served before ch0.
// 4 done pulsed in START cycle and while IDLE -> ignored; op completes only on
//   later done in WAIT; ack toggles exactly once.
// 5 reset asserted during WAIT with sel=1 -> next cycle grant=0, ack=0,
//   start=0, state IDLE; fresh req toggle after release served normally.
// 6 ch0 re-toggles immediately after each ack, ch2 pending -> alternates 0,2,0;
//   ch0 never served back-to-back while ch2 pending.

Source files
------------

// File: rtl/reqack_arb.sv
// Round-robin arbiter that lets N toggle-handshake requesters share one resource.
// The resource is driven by a single-cycle start pulse and signals completion with done.
module reqack_arb #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] sel,
  output logic            start,
  input  logic            done,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT, ACK} stateT;

  localparam logic [SELW-1:0] LastInit = SELW'(N - 1);

  stateT           r_state;
  stateT           w_nextState;
  logic [N-1:0]    r_sync1;
  logic [N-1:0]    r_sync2;
  logic [N-1:0]    r_ack;
  logic [N-1:0]    r_pending;
  logic [SELW-1:0] r_sel;
  logic [SELW-1:0] r_last;
  logic [N-1:0]    w_selOneHot;
  logic            w_found;
  logic [SELW-1:0] w_winSel;
  logic [SELW-1:0] w_idx;

  assign w_selOneHot = {{(N-1){1'b0}}, 1'b1} << r_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A pending flag is raised while the synchronised request differs from the ack.
  // Flipping the ack therefore retires exactly one request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_ack     <= '0;
      r_pending <= '0;
      r_sel     <= '0;
      r_last    <= LastInit;
    end else begin
      r_sync1   <= req;
      r_sync2   <= r_sync1;
      r_pending <= r_sync2 ^ r_ack;
      if (r_state == IDLE && w_found) begin
        r_sel <= w_winSel;
      end
      if (r_state == WAIT && done) begin
        r_ack  <= r_ack ^ w_selOneHot;
        r_last <= r_sel;
      end
    end
  end

  // The scan starts just after the last winner and wraps modulo N.
  // This makes the most recently served channel the lowest priority.
  always_comb begin
    w_found  = 1'b0;
    w_winSel = '0;
    w_idx    = '0;
    for (int i = 1; i <= N; i++) begin
      w_idx = SELW'((int'(r_last) + i) % N);
      if (!w_found && r_pending[w_idx]) begin
        w_found  = 1'b1;
        w_winSel = w_idx;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    start       = 1'b0;
    grant       = '0;
    case (r_state)
      IDLE:  if (w_found) w_nextState = START;
      START: begin
        start       = 1'b1;
        grant       = w_selOneHot;
        w_nextState = WAIT;
      end
      WAIT: begin
        grant = w_selOneHot;
        if (done) w_nextState = ACK;
      end
      ACK:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  assign ack     = r_ack;
  assign pending = r_pending;
  assign sel     = r_sel;
  assign busy    = (r_state != IDLE);

endmodule
